quick_spi_slave: RTL and testbench
==================================

Name: quick_spi_slave

Overview:
- SPI target (slave) end of the quick_spi link: receives bytes clocked in by an SPI master and returns one byte per frame slot on MISO.
- Mode 0 (CPOL=0, CPHA=0), 8-bit, MSB first.
- SCK, MOSI and SS_N are oversampled in the local clk domain, so one block serves any master clock ratio that meets the oversampling limit below.
- Sits between the external SPI pins and a local register/FIFO interface.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for sck/mosi/ss_n; minimum 2.
- IDLE_FILL, 8'hFF: byte shifted out when no tx byte is buffered.

Ports:
- clk  input  1  system clock; must be at least 4x the SCK frequency.
- rst  input  1  asynchronous, active-low reset.
- sck  input  1  SPI clock from master (asynchronous).
- ss_n  input  1  SPI select, active-low (asynchronous).
- mosi  input  1  master-out data.
- miso  output  1  slave-out data.
- tx_data  input  8  byte to return to the master.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  one-entry tx buffer empty; transfer occurs when tx_valid && tx_ready.
- rx_data  output  8  last complete received byte.
- rx_valid  output  1  one-cycle pulse; rx_data updated.
- busy  output  1  synchronised ss_n low.
- tx_underrun  output  1  one-cycle pulse; IDLE_FILL was used for a byte slot.
- frame_err  output  1  one-cycle pulse; ss_n deasserted mid-byte.

Behaviour:
- Reset values (rst low, immediate): miso 0, tx_ready 1, rx_data 8'h00, rx_valid 0, busy 0, tx_underrun 0, frame_err 0. The tx buffer is emptied, bit counter 0, state IDLE.
- Synchronisation and edge detection:
  - sck, ss_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on sck and ss_n using one extra registered copy.
  - mosi is sampled on the same cycle as the detected sck rise.
- States:
  - IDLE: ss_n high. Counter held at 0; miso driven 0.
  - IDLE -> SHIFT on ss_n fall. Load tx_shift from the tx buffer, or from IDLE_FILL plus a tx_underrun pulse if the buffer is empty. tx_ready rises the next cycle if the buffer was consumed. miso = tx_shift[7] from the following cycle.
  - SHIFT, sck rise: rx_shift <= {rx_shift[6:0], mosi_s}; bit counter +1, 3-bit, wraps 7 -> 0.
  - SHIFT, sck rise with counter == 7:
    - rx_data <= {rx_shift[6:0], mosi_s}; rx_valid pulses on the next cycle.
    - Latency from the pin edge to rx_valid is SYNC_STAGES+2 clk cycles.
  - SHIFT, sck fall with counter != 0: tx_shift shifts left; miso = new bit 7.
  - SHIFT, sck fall with counter == 0 (byte boundary): reload tx_shift from the buffer, or from IDLE_FILL plus tx_underrun, the same way as at frame start. Back-to-back bytes within one frame are supported.
  - SHIFT -> IDLE on ss_n rise:
    - counter == 0: clean end, no error.
    - counter != 0: pulse frame_err, discard the partial rx_shift, no rx_valid.
- Simultaneous events:
  - Buffer consumption and a tx_valid accept in the same cycle on an empty buffer: IDLE_FILL is shifted, the new byte stays buffered for the next slot, and tx_underrun pulses. There is no bypass path.
  - An sck edge and an ss_n rise detected in the same cycle: ss_n wins and the sck edge is ignored.
  - An sck edge while in IDLE is ignored.
- Overflow: rx_valid has no back-pressure. A consumer that misses the pulse loses the byte.
- Reset mid-frame: all state clears immediately, with no pulses. The next frame starts only on a fresh ss_n fall after reset is released.

Optional Feature:
- Macro QUICK_SPI_SLAVE_MISO_TRISTATE_EN.
- Defined:
  - Adds output miso_oe (1 bit) = synchronised ~ss_n, reset 0.
  - miso holds the last shifted bit while deselected.
  - A pad-level tristate is used for multi-slave buses.
- Undefined:
  - No miso_oe port.
  - miso is forced to 0 whenever in IDLE.

Decomposition:
- Package quick_spi_pkg:
  - Constants: QSPI_BYTE_W = 8, QSPI_CNT_W = 3.
  - The slave state typedef/encoding: IDLE = 0, SHIFT = 1.
- One sub-module, quick_spi_sync:
  - Parameterised SYNC_STAGES synchroniser with registered rise/fall outputs.
  - Instantiated for sck and ss_n.
  - mosi uses it with the edge outputs unused.

Test Plan:
- tx_data 8'hA5 preloaded; master (clk/8 SCK) sends 8'h3C in one frame -> rx_data 8'h3C with one rx_valid pulse; master receives 8'hA5; no tx_underrun or frame_err.
- No tx byte loaded; master sends 8'h81 -> master receives 8'hFF; tx_underrun pulses once; rx_data 8'h81.
- 3-byte frame sending 8'h01, 8'h02, 8'h03; tx loads 8'h10, 8'h20, 8'h30 accepted whenever tx_ready rises -> three rx_valid pulses in order; master receives 10/20/30; ss_n stays low throughout.
- ss_n raised after 5 SCK rises -> frame_err pulses once; no rx_valid; the next full frame sending 8'h5A returns rx_data 8'h5A.
- rst asserted mid-byte -> all outputs take reset values immediately; tx_ready 1; after release, a new frame behaves as in scenario 1.
- SCK toggling with ss_n high -> no rx_valid; miso 0 (macro off); miso_oe 0 (macro on).

Source files
------------

// File: rtl/quick_spi_pkg.sv
// Shared constants and state encoding for the quick_spi link.
package quick_spi_pkg;

    localparam int QSPI_BYTE_W = 8;
    localparam int QSPI_CNT_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } slave_state_e;

endpackage

// File: rtl/quick_spi_sync.sv
// Multi-stage synchroniser for one asynchronous pin with registered rise/fall strobes.
// Edge strobes stay quiet until the chain holds real samples, so a level held across reset is not seen as an edge.
module quick_spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic [SYNC_STAGES:0]   primed;

    assign q = chain[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain  <= {SYNC_STAGES{RESET_VAL}};
            prev   <= RESET_VAL;
            primed <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], d};
            prev   <= q;
            primed <= {primed[SYNC_STAGES-1:0], 1'b1};
            rise   <= primed[SYNC_STAGES] && q && !prev;
            fall   <= primed[SYNC_STAGES] && !q && prev;
        end
    end

endmodule

// File: rtl/quick_spi_slave.sv
// Quick SPI target: mode 0, 8-bit MSB-first slave oversampled in the clk domain.
// Define QUICK_SPI_SLAVE_MISO_TRISTATE_EN to add miso_oe and hold miso while deselected.
module quick_spi_slave
    import quick_spi_pkg::*;
#(
    parameter int                     SYNC_STAGES = 2,
    parameter logic [QSPI_BYTE_W-1:0] IDLE_FILL   = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sck,
    input  logic                   ss_n,
    input  logic                   mosi,
    output logic                   miso,
`ifdef QUICK_SPI_SLAVE_MISO_TRISTATE_EN
    output logic                   miso_oe,
`endif
    input  logic [QSPI_BYTE_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [QSPI_BYTE_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   tx_underrun,
    output logic                   frame_err
);

    logic sck_rise, sck_fall, sck_unused_level;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_unused_rise, mosi_unused_fall;

    quick_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .d(sck), .q(sck_unused_level), .rise(sck_rise), .fall(sck_fall)
    );

    quick_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .d(ss_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    quick_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
    );

    slave_state_e                 state_q, state_d;
    logic [QSPI_CNT_W-1:0]        bit_cnt;
    logic [QSPI_BYTE_W-2:0]       rx_shift;
    logic [QSPI_BYTE_W-1:0]       tx_shift;
    logic [QSPI_BYTE_W-1:0]       tx_buf;
    logic                         tx_full;
    logic                         tx_take;
    logic                         load_tx, shift_tx, sample_rx, end_frame;

    assign tx_take = tx_valid && !tx_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        load_tx   = 1'b0;
        shift_tx  = 1'b0;
        sample_rx = 1'b0;
        end_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    load_tx = 1'b1;
                end
            end
            SHIFT: begin
                // A deselect outranks any sck edge seen in the same cycle.
                if (ss_rise) begin
                    state_d   = IDLE;
                    end_frame = 1'b1;
                end else if (sck_rise) begin
                    sample_rx = 1'b1;
                end else if (sck_fall) begin
                    if (bit_cnt == '0) load_tx  = 1'b1;
                    else               shift_tx = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= end_frame && (bit_cnt != '0);

            if (end_frame) begin
                bit_cnt <= '0;
            end else if (sample_rx) begin
                bit_cnt  <= bit_cnt + QSPI_CNT_W'(1);
                rx_shift <= {rx_shift[QSPI_BYTE_W-3:0], mosi_s};
                if (bit_cnt == '1) begin
                    rx_data  <= {rx_shift, mosi_s};
                    rx_valid <= 1'b1;
                end
            end

            // A byte accepted in the same cycle as a load waits for the next slot.
            if (load_tx) begin
                tx_shift    <= tx_full ? tx_buf : IDLE_FILL;
                tx_underrun <= !tx_full;
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[QSPI_BYTE_W-2:0], 1'b0};
            end

            tx_full <= (tx_full && !load_tx) || tx_take;
        end
    end

    // NOTE: the payload register carries no reset; tx_full decides whether its contents are meaningful.
    always_ff @(posedge clk) begin
        if (tx_take) tx_buf <= tx_data;
    end

    assign tx_ready = !tx_full;
    assign busy     = !ss_s;

`ifdef QUICK_SPI_SLAVE_MISO_TRISTATE_EN
    assign miso    = tx_shift[QSPI_BYTE_W-1];
    assign miso_oe = !ss_s;
`else
    assign miso = (state_q == SHIFT) ? tx_shift[QSPI_BYTE_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_quick_spi_slave.sv
// Directed bench for quick_spi_slave: an SCK = clk/8 master drives frames and checks both data directions.
module tb_quick_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
`ifdef QUICK_SPI_SLAVE_MISO_TRISTATE_EN
    logic       miso_oe;
`endif
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rise_cyc = 0;
    int last_rx_cyc = 0;
    int rx_cnt = 0;
    int ur_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    quick_spi_slave dut (
        .clk(clk),
        .rst(rst),
        .sck(sck),
        .ss_n(ss_n),
        .mosi(mosi),
        .miso(miso),
`ifdef QUICK_SPI_SLAVE_MISO_TRISTATE_EN
        .miso_oe(miso_oe),
`endif
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .tx_underrun(tx_underrun),
        .frame_err(frame_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) begin
                rx_cnt++;
                rx_q.push_back(rx_data);
                last_rx_cyc = cyc;
            end
            if (tx_underrun) ur_cnt++;
            if (frame_err)   fe_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] pop_rx();
        if (rx_q.size() == 0) return 8'hxx;
        return rx_q.pop_front();
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},        32'(miso),        32'h0);
        check({tag, "_tx_ready"},    32'(tx_ready),    32'h1);
        check({tag, "_rx_data"},     32'(rx_data),     32'h00);
        check({tag, "_rx_valid"},    32'(rx_valid),    32'h0);
        check({tag, "_busy"},        32'(busy),        32'h0);
        check({tag, "_tx_underrun"}, 32'(tx_underrun), 32'h0);
        check({tag, "_frame_err"},   32'(frame_err),   32'h0);
    endtask

    task automatic load_tx(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", 32'(tx_ready), 32'h1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic ss_select();
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Final SCK fall of the last byte coincides with ss_n rising, so no trailing slot is opened.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit last, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = mo[i];
            repeat (4) @(negedge clk);
            mi[i] = miso;
            sck = 1'b1;
            rise_cyc = cyc;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            if (last && i == 0) ss_n = 1'b1;
        end
    endtask

    task automatic frame1(input logic [7:0] mo, output logic [7:0] mi);
        ss_select();
        spi_bits(mo, 8, 1'b1, mi);
        repeat (8) @(negedge clk);
    endtask

    task automatic scenario_basic(input string tag);
        int rx0, ur0, fe0;
        logic [7:0] mi;
        load_tx(8'hA5);
        rx0 = rx_cnt; ur0 = ur_cnt; fe0 = fe_cnt;
        frame1(8'h3C, mi);
        check({tag, "_rx_pulses"},   32'(rx_cnt - rx0),             32'd1);
        check({tag, "_rx_data"},     32'(pop_rx()),                 32'h3C);
        check({tag, "_miso_byte"},   32'(mi),                       32'hA5);
        check({tag, "_underruns"},   32'(ur_cnt - ur0),             32'd0);
        check({tag, "_frame_errs"},  32'(fe_cnt - fe0),             32'd0);
        check({tag, "_rx_latency"},  32'(last_rx_cyc - rise_cyc),   32'd4);
    endtask

    initial begin
        int rx0, ur0, fe0;
        logic [7:0] mi, mi1, mi2, mi3;

        #1 rst = 1'b0;
        #1 check_reset_values("por");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // Preloaded byte, single-byte frame.
        scenario_basic("s1");

        // Empty buffer: idle fill goes out and underrun pulses once.
        rx0 = rx_cnt; ur0 = ur_cnt;
        frame1(8'h81, mi);
        check("s2_miso_byte", 32'(mi),           32'hFF);
        check("s2_underruns", 32'(ur_cnt - ur0), 32'd1);
        check("s2_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("s2_rx_data",   32'(pop_rx()),     32'h81);

        // Three back-to-back bytes in one frame, tx refilled as slots open.
        rx0 = rx_cnt; ur0 = ur_cnt;
        load_tx(8'h10);
        ss_select();
        load_tx(8'h20);
        spi_bits(8'h01, 8, 1'b0, mi1);
        load_tx(8'h30);
        spi_bits(8'h02, 8, 1'b0, mi2);
        check("s3_busy_mid", 32'(busy), 32'h1);
        spi_bits(8'h03, 8, 1'b1, mi3);
        repeat (8) @(negedge clk);
        check("s3_rx_pulses", 32'(rx_cnt - rx0), 32'd3);
        check("s3_rx0",       32'(pop_rx()),     32'h01);
        check("s3_rx1",       32'(pop_rx()),     32'h02);
        check("s3_rx2",       32'(pop_rx()),     32'h03);
        check("s3_miso0",     32'(mi1),          32'h10);
        check("s3_miso1",     32'(mi2),          32'h20);
        check("s3_miso2",     32'(mi3),          32'h30);
        check("s3_underruns", 32'(ur_cnt - ur0), 32'd0);

        // Deselect after five bits: frame error, partial byte dropped.
        rx0 = rx_cnt; fe0 = fe_cnt;
        ss_select();
        spi_bits(8'hF8, 5, 1'b0, mi);
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
        check("s4_frame_errs", 32'(fe_cnt - fe0), 32'd1);
        check("s4_rx_pulses",  32'(rx_cnt - rx0), 32'd0);
        frame1(8'h5A, mi);
        check("s4_next_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("s4_next_rx",     32'(pop_rx()),     32'h5A);
        check("s4_next_errs",   32'(fe_cnt - fe0), 32'd1);

        // Reset mid-byte with a byte still buffered.
        load_tx(8'hA5);
        ss_select();
        load_tx(8'h77);
        check("s5_pre_tx_ready", 32'(tx_ready), 32'h0);
        spi_bits(8'hE0, 3, 1'b0, mi);
        rst = 1'b0;
        #1 check_reset_values("s5_rst");
        ss_n = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("s5_post_tx_ready", 32'(tx_ready), 32'h1);
        scenario_basic("s5_after");

        // SCK activity while deselected is ignored.
        rx0 = rx_cnt; ur0 = ur_cnt;
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            sck  = 1'b1;
            repeat (4) @(negedge clk);
`ifdef QUICK_SPI_SLAVE_MISO_TRISTATE_EN
            check("s6_miso_oe", 32'(miso_oe), 32'h0);
`else
            check("s6_miso", 32'(miso), 32'h0);
`endif
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("s6_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
        check("s6_underruns", 32'(ur_cnt - ur0), 32'd0);
        check("s6_busy",      32'(busy),         32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
